// File: rtl/cla_ctrl_pkg.sv
// cla_ctrl_pkg: shared constants, state encoding and index sizing for the serial CLA adder
package cla_ctrl_pkg;
  localparam int NIB = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic int idx_w(input int width);
    return (width / NIB) <= 1 ? 1 : $clog2(width / NIB);
  endfunction
endpackage

// File: rtl/cla_serial_add_ctrl_slice.sv
// cla4_slice: combinational 4-bit carry-lookahead adder
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g, p;
  logic [4:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s = p ^ c[3:0];
  assign co = c[4];
endmodule

// File: rtl/cla_serial_add_ctrl.sv
// cla_serial_add_ctrl: WIDTH-bit adder built by sequencing one 4-bit CLA slice, LSB nibble first
module cla_serial_add_ctrl
  import cla_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);
  localparam int NN = WIDTH / NIB;
  localparam int IW = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NN - 1);
  if (WIDTH % NIB != 0 || WIDTH < NIB) begin : g_bad_width
    $error("cla_serial_add_ctrl: WIDTH must be a positive multiple of 4");
  end
  state_t state;
  logic [IW-1:0] idx;
  logic cr;
  logic [WIDTH-1:0] ra, rb;
  logic [NIB-1:0] na, nb, ns;
  logic nc;
  assign na = ra[idx*NIB +: NIB];
  assign nb = rb[idx*NIB +: NIB];
  cla4_slice u_slice (.a(na), .b(nb), .ci(cr), .s(ns), .co(nc));
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cr <= 1'b0;
      ra <= '0;
      rb <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          ra <= a;
          rb <= b;
          cr <= cin;
          idx <= '0;
          state <= RUN;
        end
        RUN: begin
          sum[idx*NIB +: NIB] <= ns;
          cr <= nc;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            cout <= nc;
            ovf <= (ra[WIDTH-1] == rb[WIDTH-1]) & (ns[NIB-1] != ra[WIDTH-1]);
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_serial_add_ctrl.sv
// tb_cla_serial_add_ctrl: directed checks of the serial CLA adder at WIDTH 16, 4 and 32
module tb_cla_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic cin = 1'b0;
  logic [2:0] iv = '0, ordy = '0;
  logic [2:0] irdy, ov, co, of, bz;
  logic [15:0] s16;
  logic [3:0] s4;
  logic [31:0] s32;
  int tests = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cla_serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(a[15:0]), .b(b[15:0]), .cin(cin), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s16),
    .cout(co[0]), .ovf(of[0]), .busy(bz[0]));
  cla_serial_add_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s4),
    .cout(co[1]), .ovf(of[1]), .busy(bz[1]));
  cla_serial_add_ctrl #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(a), .b(b), .cin(cin), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s32),
    .cout(co[2]), .ovf(of[2]), .busy(bz[2]));
  function automatic logic [31:0] sumk(input int k);
    return k == 0 ? {16'h0, s16} : k == 1 ? {28'h0, s4} : s32;
  endfunction
  // returns {ovf, cout, sum} computed with a plain full-width add
  function automatic logic [33:0] ref_add(input logic [31:0] x, y, input logic c, input int w);
    logic [32:0] t;
    logic [31:0] m;
    m = w == 32 ? 32'hFFFF_FFFF : (32'h1 << w) - 32'h1;
    t = {1'b0, x & m} + {1'b0, y & m} + {32'h0, c};
    return {(x[w-1] == y[w-1]) && (t[w-1] != x[w-1]), t[w], t[31:0] & m};
  endfunction
  task automatic run_op(input int k, input logic [31:0] aa, bb, input logic c, input logic rdy,
                        output logic [31:0] s, output logic co_o, of_o, output int lat);
    @(negedge clk);
    a = aa; b = bb; cin = c; iv[k] = 1'b1; ordy[k] = rdy;
    @(posedge clk);
    @(negedge clk);
    iv[k] = 1'b0; a = 32'hDEAD_DEAD; b = 32'hDEAD_DEAD; cin = ~c;
    lat = 0;
    while (!ov[k] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    s = sumk(0 + k); co_o = co[k]; of_o = of[k];
  endtask
  task automatic test_reset();
    #1;
    tests++;
    if ({irdy[0], ov[0], bz[0], s16, co[0], of[0]} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset: rdy=%b ov=%b busy=%b sum=%h co=%b ovf=%b, want 1 0 0 0000 0 0",
               irdy[0], ov[0], bz[0], s16, co[0], of[0]);
    end
  endtask
  task automatic test_basic();
    logic [31:0] s; logic c, o; int lat;
    run_op(0, 32'hFFFF, 32'h0001, 1'b0, 1'b1, s, c, o, lat);
    tests++;
    if (lat != 4) begin fails++; $display("FAIL latency: got %0d want 4", lat); end
    tests++;
    if ({o, c, s} !== {1'b0, 1'b1, 32'h0000}) begin
      fails++; $display("FAIL ffff+1: got ovf=%b co=%b sum=%h want 0 1 0000", o, c, s);
    end
    run_op(0, 32'h7FFF, 32'h0001, 1'b0, 1'b1, s, c, o, lat);
    tests++;
    if ({o, c, s} !== {1'b1, 1'b0, 32'h8000}) begin
      fails++; $display("FAIL 7fff+1: got ovf=%b co=%b sum=%h want 1 0 8000", o, c, s);
    end
    run_op(0, 32'h8000, 32'h8000, 1'b0, 1'b1, s, c, o, lat);
    tests++;
    if ({o, c, s} !== {1'b1, 1'b1, 32'h0000}) begin
      fails++; $display("FAIL 8000+8000: got ovf=%b co=%b sum=%h want 1 1 0000", o, c, s);
    end
    run_op(0, 32'h1234, 32'h4321, 1'b1, 1'b1, s, c, o, lat);
    tests++;
    if ({o, c, s} !== {1'b0, 1'b0, 32'h5556}) begin
      fails++; $display("FAIL 1234+4321+1: got ovf=%b co=%b sum=%h want 0 0 5556", o, c, s);
    end
    run_op(0, 32'h0, 32'h0, 1'b0, 1'b1, s, c, o, lat);
    tests++;
    if ({o, c, s} !== {1'b0, 1'b0, 32'h0}) begin
      fails++; $display("FAIL zero: got ovf=%b co=%b sum=%h want 0 0 0000", o, c, s);
    end
    run_op(0, 32'hFFFF, 32'hFFFF, 1'b1, 1'b1, s, c, o, lat);
    tests++;
    if ({o, c, s} !== {1'b0, 1'b1, 32'hFFFF}) begin
      fails++; $display("FAIL ones: got ovf=%b co=%b sum=%h want 0 1 ffff", o, c, s);
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] s; logic c, o; int lat; int bad;
    run_op(0, 32'h00F0, 32'h0F10, 1'b0, 1'b0, s, c, o, lat);
    bad = 0;
    iv[0] = 1'b1; a = 32'h1111; b = 32'h2222;
    repeat (6) begin
      @(negedge clk);
      if (!ov[0] || irdy[0] || s16 !== 16'h1000 || co[0] || of[0]) bad++;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL hold: %0d bad cycles, want 0 (sum=%h)", bad, s16); end
    ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    tests++;
    if ({irdy[0], ov[0], bz[0]} !== 3'b100) begin
      fails++; $display("FAIL release: rdy/ov/busy=%b want 100", {irdy[0], ov[0], bz[0]});
    end
  endtask
  task automatic test_reset_mid_run();
    logic [31:0] s; logic c, o; int lat; int seen;
    @(negedge clk);
    a = 32'hAAAA; b = 32'h5555; cin = 1'b1; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    tests++;
    if (bz[0] !== 1'b1) begin fails++; $display("FAIL busy_run: got %b want 1", bz[0]); end
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({irdy[0], ov[0], bz[0], s16, co[0], of[0]} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL async_rst: rdy=%b ov=%b busy=%b sum=%h co=%b ovf=%b, want 1 0 0 0000 0 0",
               irdy[0], ov[0], bz[0], s16, co[0], of[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ov[0]) seen++;
    end
    tests++;
    if (seen != 0) begin fails++; $display("FAIL no_pulse: out_valid seen %0d cycles, want 0", seen); end
    run_op(0, 32'h0003, 32'h0004, 1'b0, 1'b1, s, c, o, lat);
    tests++;
    if ({o, c, s} !== {1'b0, 1'b0, 32'h0007}) begin
      fails++; $display("FAIL after_rst: got ovf=%b co=%b sum=%h want 0 0 0007", o, c, s);
    end
  endtask
  task automatic test_back_to_back(input int k, input int w);
    logic [31:0] ea, eb; logic ec; logic [33:0] e, got;
    int g, acc, prev, lat, bad_val, bad_gap;
    bad_val = 0; bad_gap = 0; prev = 0;
    @(negedge clk);
    a = $urandom; b = $urandom; cin = 1'($urandom); iv[k] = 1'b1; ordy[k] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      g = 0;
      while (!irdy[k] && g < 20) begin @(negedge clk); g++; end
      ea = a; eb = b; ec = cin;
      @(posedge clk);
      @(negedge clk);
      acc = cyc;
      if (i > 0 && acc - prev != w / 4 + 2) begin
        bad_gap++; $display("FAIL gap w%0d: op %0d spacing %0d want %0d", w, i, acc - prev, w / 4 + 2);
      end
      prev = acc;
      a = $urandom; b = $urandom; cin = 1'($urandom);
      lat = 0;
      while (!ov[k] && lat < 50) begin @(negedge clk); lat++; end
      e = ref_add(ea, eb, ec, w);
      got = {of[k], co[k], sumk(k)};
      if (got !== e) begin
        bad_val++; $display("FAIL b2b w%0d: op %0d got %h want %h", w, i, got, e);
      end
    end
    iv[k] = 1'b0;
    tests++;
    if (bad_val != 0) begin fails++; $display("FAIL b2b_values w%0d: %0d wrong, want 0", w, bad_val); end
    tests++;
    if (bad_gap != 0) begin fails++; $display("FAIL b2b_spacing w%0d: %0d wrong, want 0", w, bad_gap); end
    @(negedge clk);
    @(negedge clk);
  endtask
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    test_reset();
    #20 rst = 1'b0;
    test_basic();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back(0, 16);
    test_back_to_back(1, 4);
    test_back_to_back(2, 32);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cla_serial_add_ctrl.md
Name: cla_serial_add_ctrl

Overview:
Multi-cycle controller that performs a WIDTH-bit addition by sequencing one 4-bit carry-lookahead slice over WIDTH/4 cycles, least-significant nibble first.
It trades latency for area in datapaths where a full-width CLA is too large.
Operands enter through a valid/ready handshake, and results leave through a second valid/ready handshake.
Carry and signed-overflow flags are reported with the sum.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise).
- NIB, 4, slice width; fixed constant taken from the shared package, not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  out  1  carry out of the MSB.
- ovf  out  1  signed overflow.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. Internal nibble index=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE. The encoding lives in the package.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a, b, and cin (into the carry register), clear the index, and go to RUN.
  - in_valid without a handshake has no effect.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, the slice adds nibble[idx] of the latched a and b with the carry register.
  - The slice sum is written into sum[4*idx+3:4*idx], and the slice carry-out is written to the carry register.
  - idx increments each cycle.
  - On the cycle idx==WIDTH/4-1, also write cout from the slice carry-out and ovf = (a_msb==b_msb) & (new sum_msb != a_msb), then go to DONE.
- DONE:
  - out_valid=1; sum, cout, and ovf are held stable.
  - Stay in DONE while out_ready=0.
  - On out_ready=1, go to IDLE and drop out_valid.
  - sum, cout, and ovf hold their values until the next RUN overwrites them.
- Latency: with acceptance on edge k, out_valid rises after edge k+WIDTH/4, which is 4 cycles for WIDTH=16.
- Throughput: at most one operation per WIDTH/4+2 cycles with out_ready held high. in_ready does not reassert in the DONE cycle; there is no overlap.
- Partial sum: sum is not valid while out_valid=0. Lower nibbles update progressively during RUN. Consumers must not sample sum outside out_valid.
- Input stability: a, b, and cin are registered on acceptance, so input changes after the handshake have no effect.
- Reset mid-operation (RUN or DONE): immediate return to reset values. The in-flight operation is dropped with no partial result and no out_valid pulse.
- out_ready while not in DONE: ignored.
- Wrap-around: the sum is modulo 2^WIDTH. The carry beyond the MSB appears only on cout.
- Boundary cases: 0+0+0 gives sum=0, cout=0, ovf=0. All-ones + all-ones + 1 gives sum=all-ones, cout=1, ovf=0.

Decomposition:
- Package cla_ctrl_pkg:
  - state enum {IDLE, RUN, DONE};
  - localparam NIB=4;
  - an index-width function clog2(WIDTH/NIB), with a minimum of 1.
- Sub-module cla4_slice: purely combinational 4-bit carry-lookahead adder (a[3:0], b[3:0], ci → s[3:0], co) using g/p generate-propagate terms.
  - Instantiated once.
  - The controller holds all state, operand registers, the nibble mux, and the result registers.

Test Plan:
1. WIDTH=16: a=0xFFFF, b=0x0001, cin=0, out_ready=1. Expect sum=0x0000, cout=1, ovf=0, with out_valid exactly 4 cycles after the accept edge.
2. a=0x7FFF, b=0x0001, cin=0. Expect sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x8000. Expect sum=0x0000, cout=1, ovf=1.
3. a=0x1234, b=0x4321, cin=1. Expect sum=0x5556, cout=0, ovf=0. Change a and b to 0xDEAD during RUN; the result is unchanged.
4. Backpressure: hold out_ready=0 for 6 cycles in DONE. Expect out_valid held at 1, sum/cout/ovf stable, in_ready=0, and in_valid ignored. Raise out_ready: IDLE on the next edge, and in_ready=1.
5. Reset mid-RUN: assert rst asynchronously after 2 RUN cycles. Expect all outputs at their reset values immediately, no out_valid, and a subsequent 0x0003+0x0004 giving 0x0007.
6. Back-to-back: in_valid and out_ready held high with 8 random operand pairs. Expect each result to match a reference model, with accept-to-accept spacing of exactly 6 cycles. Repeat with WIDTH=4 (1-cycle RUN) and WIDTH=32.
